// File: rtl/code_stream_packer.sv
// Packs CODE_W-bit encoder codes LSB-first into CODE_W*N_CODES-bit words with a
// valid/ready output, a flush for partial words, and a count of valid codes per word.
module code_stream_packer #(
    parameter int unsigned CODE_W  = 2,
    parameter int unsigned N_CODES = 4,
    parameter int unsigned CNT_W   = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [CODE_W-1:0]          in_code,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [CODE_W*N_CODES-1:0]  out_data,
    output logic [CNT_W-1:0]           out_count,
    input  logic                       out_ready
);

    localparam int unsigned      DATA_W    = CODE_W * N_CODES;
    localparam logic [CNT_W-1:0] LastSlot  = CNT_W'(N_CODES - 1);
    localparam logic [CNT_W-1:0] FullCount = CNT_W'(N_CODES);

    typedef enum logic [0:0] {StFill, StFlushWait} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]    out_count_q, out_count_d;

    logic                out_free;
    logic                accept;
    logic                last_slot;
    logic [DATA_W-1:0]   acc_next;
    logic [CNT_W-1:0]    cnt_next;
    logic                load;
    logic [DATA_W-1:0]   load_data;
    logic [CNT_W-1:0]    load_count;

    assign out_free  = !out_valid_q || out_ready;
    assign in_ready  = (state_q == StFill) && ((cnt_q != LastSlot) || out_free);
    assign accept    = in_valid && in_ready;
    assign last_slot = accept && (cnt_q == LastSlot);
    assign cnt_next  = cnt_q + CNT_W'(accept);

    // Accumulator including this cycle's accepted code, so flush can merge it.
    always_comb begin
        acc_next = acc_q;
        for (int unsigned i = 0; i < N_CODES; i++) begin
            if (accept && (cnt_q == CNT_W'(i))) begin
                acc_next[i*CODE_W +: CODE_W] = in_code;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        load       = 1'b0;
        load_data  = acc_next;
        load_count = cnt_next;

        case (state_q)
            StFill: begin
                if (last_slot) begin
                    // A full word consumes any flush arriving with it.
                    load       = 1'b1;
                    load_count = FullCount;
                    cnt_d      = '0;
                    acc_d      = '0;
                end else if (flush && ((cnt_q != '0) || accept)) begin
                    if (out_free) begin
                        load  = 1'b1;
                        cnt_d = '0;
                        acc_d = '0;
                    end else begin
                        cnt_d   = cnt_next;
                        acc_d   = acc_next;
                        state_d = StFlushWait;
                    end
                end else begin
                    cnt_d = cnt_next;
                    acc_d = acc_next;
                end
            end
            StFlushWait: begin
                if (out_free) begin
                    load       = 1'b1;
                    load_data  = acc_q;
                    load_count = cnt_q;
                    cnt_d      = '0;
                    acc_d      = '0;
                    state_d    = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = load_data;
            out_count_d = load_count;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StFill;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_code_stream_packer.sv
// Directed and randomised-handshake bench for code_stream_packer; popped words are
// scored against a queue of hand-computed or modelled words.
module tb_code_stream_packer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] in_code;
    logic       in_ready;
    logic       flush;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] out_count;
    logic       out_ready;

    int          errors = 0;
    int          checks = 0;
    logic [10:0] expq[$];
    logic        rnd_mode = 1'b0;
    int          mcnt = 0;
    logic [7:0]  macc = 8'h00;
    logic        hold_q = 1'b0;
    logic [7:0]  hold_data = 8'h00;
    logic [2:0]  hold_count = 3'd0;

    code_stream_packer #(
        .CODE_W (2),
        .N_CODES(4),
        .CNT_W  (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_code  (in_code),
        .in_ready (in_ready),
        .flush    (flush),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_count(out_count),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] code);
        in_valid = 1'b1;
        in_code  = code;
        tick();
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                           input logic [2:0] c);
        check({tag, "_valid"}, out_valid, v);
        if (v) begin
            check({tag, "_data"}, out_data, d);
            check({tag, "_count"}, out_count, c);
        end
    endtask

    // Monitor at negedge: score pops, check hold stability, run random-phase model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && hold_q) begin
                check("hold_data", out_data, hold_data);
                check("hold_count", out_count, hold_count);
            end
            hold_q     = rst_n && out_valid && !out_ready;
            hold_data  = out_data;
            hold_count = out_count;
            if (rst_n && out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("pop_extra", expq.size(), 1);
                end else begin
                    logic [10:0] w;
                    w = expq.pop_front();
                    check("pop_data", out_data, w[7:0]);
                    check("pop_count", out_count, w[10:8]);
                end
            end
            if (rnd_mode && rst_n) begin
                check("rnd_ready", in_ready, (mcnt != 3) || !out_valid || out_ready);
                if (in_valid && in_ready) begin
                    macc[mcnt*2 +: 2] = in_code;
                    mcnt++;
                    if (mcnt == 4) begin
                        expq.push_back({3'd4, macc});
                        mcnt = 0;
                        macc = 8'h00;
                    end
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = 2'b00;
        flush     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_count", out_count, 0);
        rst_n = 1'b1;
        tick();
        check("idle_ready", in_ready, 1);

        // T1: basic word
        out_ready = 1'b1;
        expq.push_back({3'd4, 8'h39});
        send(2'b01); send(2'b10); send(2'b11); send(2'b00);
        in_valid = 1'b0;
        chk_out("t1", 1'b1, 8'h39, 3'd4);
        tick();
        check("t1_one_cycle", out_valid, 0);

        // T2: back-pressure, then pop+reload with no bubble
        out_ready = 1'b0;
        expq.push_back({3'd4, 8'hE4});
        expq.push_back({3'd4, 8'h4F});
        send(2'b00); send(2'b01); send(2'b10); send(2'b11);
        send(2'b11); send(2'b11); send(2'b00);
        in_valid = 1'b1;
        in_code  = 2'b01;
        #1;
        check("t2_ready_blocked", in_ready, 0);
        chk_out("t2_hold1", 1'b1, 8'hE4, 3'd4);
        tick();
        check("t2_ready_blocked2", in_ready, 0);
        chk_out("t2_hold2", 1'b1, 8'hE4, 3'd4);
        out_ready = 1'b1;
        #1;
        check("t2_ready_comb", in_ready, 1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk_out("t2_reload", 1'b1, 8'h4F, 3'd4);
        tick();
        chk_out("t2_hold3", 1'b1, 8'h4F, 3'd4);
        out_ready = 1'b1;
        tick();
        check("t2_drained", out_valid, 0);

        // T3: flush of partial word, next word restarts at slot 0
        expq.push_back({3'd2, 8'h07});
        expq.push_back({3'd4, 8'h02});
        send(2'b11); send(2'b01);
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        chk_out("t3_flush", 1'b1, 8'h07, 3'd2);
        send(2'b10); send(2'b00); send(2'b00); send(2'b00);
        in_valid = 1'b0;
        chk_out("t3_next", 1'b1, 8'h02, 3'd4);
        tick();

        // T4: empty flush is a no-op
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_noop", out_valid, 0);
        tick();
        check("t4_noop2", out_valid, 0);

        // T5: flush with the 3rd code
        expq.push_back({3'd3, 8'h1A});
        send(2'b10); send(2'b10);
        flush = 1'b1;
        send(2'b01);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_out("t5_flush", 1'b1, 8'h1A, 3'd3);
        tick();

        // T7: flush while output is blocked waits, blocks input, ignores re-flush
        out_ready = 1'b0;
        expq.push_back({3'd4, 8'h55});
        expq.push_back({3'd2, 8'h0E});
        send(2'b01); send(2'b01); send(2'b01); send(2'b01);
        send(2'b10);
        flush = 1'b1;
        send(2'b11);
        in_code = 2'b01;
        #1;
        check("t7_pend_ready", in_ready, 0);
        tick();
        chk_out("t7_hold", 1'b1, 8'h55, 3'd4);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("t7_pend_ready2", in_ready, 0);
        tick();
        chk_out("t7_partial", 1'b1, 8'h0E, 3'd2);
        check("t7_ready_back", in_ready, 1);
        tick();
        check("t7_drained", out_valid, 0);

        // T6: reset mid-word discards held and partial words
        out_ready = 1'b0;
        send(2'b11); send(2'b11); send(2'b11); send(2'b11);
        send(2'b01); send(2'b01);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_data", out_data, 0);
        check("t6_rst_count", out_count, 0);
        tick();
        check("t6_rst_valid2", out_valid, 0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        expq.push_back({3'd4, 8'hC0});
        send(2'b00); send(2'b00); send(2'b00); send(2'b11);
        in_valid = 1'b0;
        chk_out("t6_word", 1'b1, 8'hC0, 3'd4);
        tick();

        // Randomised handshakes
        mcnt     = 0;
        macc     = 8'h00;
        rnd_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_code   = 2'($urandom_range(0, 3));
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rnd_mode = 1'b0;
        if (mcnt > 0) begin
            expq.push_back({3'(mcnt), macc});
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        tick();
        check("queue_empty", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
